// File: rtl/daq_pkg.sv
// Shared DAQ definitions: default ADC beat geometry and the capture FSM encoding.
package daq_pkg;

  localparam int DAQ_SAMPLE_WIDTH     = 16;
  localparam int DAQ_PARALLEL_SAMPLES = 16;

  // Encoding is visible on the state port: IDLE=0, CAPTURE=1, READOUT=2.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2
  } daq_state_e;

endpackage

// File: rtl/adc_sample_buffer_if.sv
// Bus bundle for adc_sample_buffer: ADC AXIS input, control pulses,
// readout AXIS output and status. slave = buffer side, master = driver side.
interface adc_sample_buffer_if
  import daq_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = DAQ_SAMPLE_WIDTH,
  parameter int PARALLEL_SAMPLES = DAQ_PARALLEL_SAMPLES,
  parameter int BUFFER_DEPTH     = 1024
);
  localparam int W  = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  logic [W-1:0]  s_axis_adc_tdata;
  logic          s_axis_adc_tvalid;
  logic          s_axis_adc_tready;
  logic          capture_start;
  logic          capture_stop;
  logic          readout_start;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [CW-1:0] word_count;
  daq_state_e    state;
  logic          full;

  modport slave (
    input  s_axis_adc_tdata, s_axis_adc_tvalid, capture_start, capture_stop,
           readout_start, m_axis_tready,
    output s_axis_adc_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           word_count, state, full
  );

  modport master (
    output s_axis_adc_tdata, s_axis_adc_tvalid, capture_start, capture_stop,
           readout_start, m_axis_tready,
    input  s_axis_adc_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           word_count, state, full
  );

endinterface

// File: rtl/adc_buffer_ram.sv
// Simple dual-port beat store: one write port, registered read port.
// rdata only changes when re is high, so a stalled read result is held.
module adc_buffer_ram #(
  parameter  int DW    = 256,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Registered read, one-cycle latency.
  always_ff @(posedge clk)
    if (re) rdata <= mem[raddr];

endmodule

// File: rtl/adc_sample_buffer.sv
// ADC capture buffer: records AXIS beats between capture_start/capture_stop
// (or until full) and replays them on an AXIS master with backpressure.
// Optional macro ADC_BUFFER_CIRCULAR_EN: capture keeps running when full,
// overwriting the oldest beat; readout then starts at the oldest beat.
module adc_sample_buffer
  import daq_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = DAQ_SAMPLE_WIDTH,
  parameter int PARALLEL_SAMPLES = DAQ_PARALLEL_SAMPLES,
  parameter int BUFFER_DEPTH     = 1024
) (
  input logic adc_clk,
  input logic adc_reset,
  adc_sample_buffer_if.slave bus
);
  localparam int W      = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int AW     = $clog2(BUFFER_DEPTH);
  localparam int CW     = AW + 1;
  localparam int STAGES = 2;  // RAM read register + output register
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);

  daq_state_e        st, st_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_addr;
  logic [CW-1:0]     wc, rd_issued, issue_idx;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic              last_s1, m_last;
  logic [W-1:0]      ram_rdata, m_data;
  logic              is_full, wr_en, cap_go, rdo_go, cap_end;
  logic              out_adv, s1_adv, rd_issue, last_hs;

  assign is_full = (wc == DEPTH_C);
  assign wr_en   = (st == ST_CAPTURE) && bus.s_axis_adc_tvalid;
  // Capture wins over readout when both pulse in IDLE.
  assign cap_go  = (st == ST_IDLE) && bus.capture_start;
  assign rdo_go  = (st == ST_IDLE) && !bus.capture_start && bus.readout_start && (wc != '0);
`ifdef ADC_BUFFER_CIRCULAR_EN
  assign cap_end = bus.capture_stop;
`else
  assign cap_end = bus.capture_stop || (bus.s_axis_adc_tvalid && (wc == DEPTH_C - 1'b1));
`endif

  // Read pipeline: stage 2 (output) advances when empty or accepted;
  // stage 1 (RAM register) refills whenever it is empty or draining.
  assign out_adv  = !vld_q[2] || bus.m_axis_tready;
  assign s1_adv   = !vld_q[1] || out_adv;
  // First read is issued on the readout_start cycle itself so tvalid rises two cycles later.
  assign rd_issue = rdo_go || ((st == ST_READOUT) && (rd_issued != wc) && s1_adv);
  assign vld_pipe = {vld_q, rd_issue};
  // Once wrapped (full), the oldest beat sits at the write pointer; otherwise at 0.
  assign rd_addr   = rdo_go ? (is_full ? wr_ptr : '0) : rd_ptr;
  assign issue_idx = rdo_go ? '0 : rd_issued;
  assign last_hs   = vld_q[2] && bus.m_axis_tready && m_last;

  adc_buffer_ram #(.DW(W), .DEPTH(BUFFER_DEPTH)) u_ram (
    .clk   (adc_clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.s_axis_adc_tdata),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // FSM state register.
  always_ff @(posedge adc_clk or posedge adc_reset)
    if (adc_reset) st <= ST_IDLE;
    else           st <= st_nxt;

  // FSM next state.
  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE:    if (cap_go) st_nxt = ST_CAPTURE;
                  else if (rdo_go) st_nxt = ST_READOUT;
      ST_CAPTURE: if (cap_end) st_nxt = ST_IDLE;
      ST_READOUT: if (last_hs) st_nxt = ST_IDLE;
      default:    st_nxt = ST_IDLE;
    endcase
  end

  // Write pointer, beat count and read issue pointers.
  always_ff @(posedge adc_clk or posedge adc_reset)
    if (adc_reset) begin
      wr_ptr    <= '0;
      wc        <= '0;
      rd_ptr    <= '0;
      rd_issued <= '0;
      last_s1   <= 1'b0;
    end else begin
      if (cap_go) begin
        wr_ptr <= '0;
        wc     <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!is_full) wc <= wc + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr    <= rd_addr + 1'b1;
        rd_issued <= issue_idx + 1'b1;
        last_s1   <= (issue_idx == wc - 1'b1);
      end
    end

  // Pipeline valids and output register; held while stalled.
  always_ff @(posedge adc_clk or posedge adc_reset)
    if (adc_reset) begin
      vld_q  <= '0;
      m_data <= '0;
      m_last <= 1'b0;
    end else begin
      if (s1_adv) vld_q[1] <= vld_pipe[0];
      if (out_adv) begin
        vld_q[2] <= vld_q[1];
        m_last   <= vld_q[1] && last_s1;
        if (vld_q[1]) m_data <= ram_rdata;
      end
    end

  assign bus.s_axis_adc_tready = !adc_reset;
  assign bus.m_axis_tdata      = m_data;
  assign bus.m_axis_tvalid     = vld_q[2];
  assign bus.m_axis_tlast      = m_last;
  assign bus.word_count        = wc;
  assign bus.state             = st;
  assign bus.full              = is_full;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Bench for adc_sample_buffer (BUFFER_DEPTH=16). A queue model tracks what
// the buffer holds and what readout must produce; a negedge process
// compares every cycle, and scenario code adds literal expectations.
module tb_adc_sample_buffer;
  import daq_pkg::*;

  localparam int SW = 16;
  localparam int PS = 16;
  localparam int D  = 16;
  localparam int W  = SW * PS;
`ifdef ADC_BUFFER_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  typedef logic [W-1:0] beat_t;

  logic adc_clk   = 1'b0;
  logic adc_reset = 1'b1;

  adc_sample_buffer_if #(.SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .BUFFER_DEPTH(D)) bus ();

  adc_sample_buffer #(.SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .BUFFER_DEPTH(D)) dut (
    .adc_clk   (adc_clk),
    .adc_reset (adc_reset),
    .bus       (bus)
  );

  always #2 adc_clk = ~adc_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_d(string name, beat_t got, beat_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  beat_t q[$];     // beats the buffer holds, oldest first
  beat_t rdq[$];   // beats still owed by the current readout
  beat_t got[$];   // beats actually handed over in the current readout
  int    m_state = 0;
  int    rd_age  = 0;
  int    served  = 0;
  bit    hs_pend = 0, prev_hs = 0, prev_stall = 0, prev_last = 0;
  beat_t prev_data;

  always @(posedge adc_clk) begin
    if (adc_reset) begin
      m_state = 0;
      q.delete();
      rdq.delete();
    end else begin
      case (m_state)
        0: if (bus.capture_start) begin
             m_state = 1;
             q.delete();
           end else if (bus.readout_start && q.size() > 0) begin
             m_state = 2;
             rdq = q;
             rd_age = 0;
             served = 0;
           end
        1: begin
             if (bus.s_axis_adc_tvalid) begin
               if (q.size() == D) void'(q.pop_front());
               q.push_back(bus.s_axis_adc_tdata);
             end
             if (bus.capture_stop || (!CIRC && q.size() == D)) m_state = 0;
           end
        default: begin
             rd_age++;
             if (hs_pend) begin
               void'(rdq.pop_front());
               served++;
               if (rdq.size() == 0) m_state = 0;
             end
           end
      endcase
    end
    hs_pend = 0;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge adc_clk) begin
    bit hs;
    if (adc_reset) begin
      chk("rst_state", int'(bus.state), 0);
      chk("rst_word_count", int'(bus.word_count), 0);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_tvalid", int'(bus.m_axis_tvalid), 0);
      chk("rst_tlast", int'(bus.m_axis_tlast), 0);
      chk_d("rst_tdata", bus.m_axis_tdata, '0);
      chk("rst_s_tready", int'(bus.s_axis_adc_tready), 0);
      prev_hs = 0; prev_stall = 0; hs_pend = 0;
    end else begin
      chk("state", int'(bus.state), m_state);
      chk("word_count", int'(bus.word_count), q.size());
      chk("full", int'(bus.full), int'(q.size() == D));
      chk("s_tready", int'(bus.s_axis_adc_tready), 1);
      if (m_state != 2) chk("tvalid_not_readout", int'(bus.m_axis_tvalid), 0);
      else begin
        if (rd_age == 0) chk("tvalid_early", int'(bus.m_axis_tvalid), 0);
        if (rd_age == 1 && served == 0) chk("tvalid_latency", int'(bus.m_axis_tvalid), 1);
        if (prev_hs && rdq.size() > 0) chk("tvalid_sustain", int'(bus.m_axis_tvalid), 1);
        if (prev_stall) begin
          chk("stall_tvalid", int'(bus.m_axis_tvalid), 1);
          chk_d("stall_tdata", bus.m_axis_tdata, prev_data);
          chk("stall_tlast", int'(bus.m_axis_tlast), int'(prev_last));
        end
        if (bus.m_axis_tvalid) begin
          chk_d("tdata", bus.m_axis_tdata, rdq.size() > 0 ? rdq[0] : 'x);
          chk("tlast", int'(bus.m_axis_tlast), int'(rdq.size() == 1));
        end
      end
      hs = (m_state == 2) && bus.m_axis_tvalid && bus.m_axis_tready;
      if (hs) got.push_back(bus.m_axis_tdata);
      hs_pend    = hs;
      prev_hs    = hs;
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
      prev_last  = bus.m_axis_tlast;
    end
  end

  // ---------------- stimulus ----------------
  function automatic beat_t rnd();
    beat_t r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic clear_in();
    bus.capture_start     = 1'b0;
    bus.capture_stop      = 1'b0;
    bus.readout_start     = 1'b0;
    bus.s_axis_adc_tvalid = 1'b0;
    bus.s_axis_adc_tdata  = '0;
  endtask

  // The beat on the start cycle must not be stored.
  task automatic capture(int n, bit stop, bit lit);
    bus.capture_start     = 1'b1;
    bus.s_axis_adc_tvalid = 1'b1;
    bus.s_axis_adc_tdata  = beat_t'(32'hDEAD_BEEF);
    step();
    bus.capture_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.s_axis_adc_tdata = lit ? beat_t'(i + 1) : rnd();
      bus.capture_stop     = stop && (i == n - 1);
      step();
    end
    clear_in();
    step();
  endtask

  task automatic readout(bit rnd_rdy);
    got.delete();
    bus.readout_start = 1'b1;
    bus.m_axis_tready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    step();
    bus.readout_start = 1'b0;
    for (int c = 0; c < 300 && m_state == 2; c++) begin
      bus.m_axis_tready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      step();
    end
    chk("readout_done", m_state, 0);
    bus.m_axis_tready = 1'b0;
  endtask

  initial begin
    bit ps, pr, pp;
    clear_in();
    bus.m_axis_tready = 1'b0;
    adc_reset = 1'b1;
    repeat (3) step();
    @(negedge adc_clk);
    chk("lit_reset_state", int'(bus.state), 0);
    chk("lit_reset_wc", int'(bus.word_count), 0);
    step();
    adc_reset = 1'b0;
    step();

    // Readout with nothing captured is ignored.
    bus.readout_start = 1'b1; step(); bus.readout_start = 1'b0; step();
    @(negedge adc_clk);
    chk("lit_empty_readout_state", int'(bus.state), 0);
    step();

    // Five beats 1..5 then readout with tready high.
    capture(5, 1'b1, 1'b1);
    @(negedge adc_clk);
    chk("lit5_wc", int'(bus.word_count), 5);
    chk("lit5_full", int'(bus.full), 0);
    step();
    readout(1'b0);
    chk("lit5_nbeats", got.size(), 5);
    for (int i = 0; i < got.size(); i++) chk_d("lit5_beat", got[i], beat_t'(i + 1));

    // Twenty continuous beats 1..20; stop lands on the last one.
    capture(20, 1'b1, 1'b1);
    @(negedge adc_clk);
    chk("lit20_wc", int'(bus.word_count), 16);
    chk("lit20_full", int'(bus.full), 1);
    chk("lit20_state", int'(bus.state), 0);
    step();
    readout(1'b0);
    chk("lit20_nbeats", got.size(), 16);
    for (int i = 0; i < got.size(); i++)
      chk_d("lit20_beat", got[i], beat_t'(i + (CIRC ? 5 : 1)));

    // Eight random beats, random backpressure.
    capture(8, 1'b1, 1'b0);
    readout(1'b1);
    chk("rnd8_nbeats", got.size(), 8);

    // Reset after the third beat of a readout.
    capture(8, 1'b1, 1'b1);
    got.delete();
    bus.readout_start = 1'b1;
    bus.m_axis_tready = 1'b1;
    step();
    bus.readout_start = 1'b0;
    for (int c = 0; c < 50 && got.size() < 3; c++) step();
    adc_reset = 1'b1;
    @(negedge adc_clk);
    chk("lit_rst_tvalid", int'(bus.m_axis_tvalid), 0);
    chk("lit_rst_wc", int'(bus.word_count), 0);
    chk("lit_rst_state", int'(bus.state), 0);
    step();
    adc_reset = 1'b0;
    bus.readout_start = 1'b1; step(); bus.readout_start = 1'b0;
    repeat (10) step();
    @(negedge adc_clk);
    chk("lit_rst_nbeats", got.size(), 3);
    chk("lit_rst_after_state", int'(bus.state), 0);
    step();
    bus.m_axis_tready = 1'b0;

    // capture_start and readout_start together: capture wins.
    capture(3, 1'b1, 1'b0);
    bus.capture_start = 1'b1;
    bus.readout_start = 1'b1;
    bus.m_axis_tready = 1'b1;
    step();
    clear_in();
    @(negedge adc_clk);
    chk("lit_prio_state", int'(bus.state), 1);
    chk("lit_prio_wc", int'(bus.word_count), 0);
    chk("lit_prio_tvalid", int'(bus.m_axis_tvalid), 0);
    step();
    bus.s_axis_adc_tvalid = 1'b1; bus.s_axis_adc_tdata = rnd(); bus.capture_stop = 1'b1;
    step();
    clear_in();
    step();

    // Random traffic; the per-cycle model does the checking.
    ps = 0; pr = 0; pp = 0;
    for (int c = 0; c < 600; c++) begin
      bus.capture_start     = !ps && ($urandom_range(29) == 0);
      bus.capture_stop      = !pp && ($urandom_range(11) == 0);
      bus.readout_start     = !pr && ($urandom_range(9) == 0);
      bus.s_axis_adc_tvalid = ($urandom_range(9) < 7);
      bus.s_axis_adc_tdata  = rnd();
      bus.m_axis_tready     = ($urandom_range(9) < 6);
      ps = bus.capture_start; pp = bus.capture_stop; pr = bus.readout_start;
      step();
    end
    clear_in();
    bus.m_axis_tready = 1'b1;
    for (int c = 0; c < 100 && m_state != 0; c++) step();
    chk("final_idle", m_state, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_buffer.md
ADC_SAMPLE_BUFFER -- requirements
Module: adc_sample_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per ADC sample.
REQ-002 SHALL have parameter PARALLEL_SAMPLES, default 16, samples per AXIS beat; beat width W = SAMPLE_WIDTH*PARALLEL_SAMPLES (256).
REQ-003 SHALL have parameter BUFFER_DEPTH, default 1024, beats stored; power of two, at least 4.
REQ-004 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-005 SHALL have port adc_clk  input  1  capture clock (256 MHz).
REQ-006 SHALL have port adc_reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port s_axis_adc_tdata  input  W  ADC beat.
REQ-008 SHALL have port s_axis_adc_tvalid  input  1  ADC beat valid.
REQ-009 SHALL have port s_axis_adc_tready  output  1  ADC beat accepted.
REQ-010 SHALL have port capture_start  input  1  single-cycle pulse, begin capture.
REQ-011 SHALL have port capture_stop  input  1  single-cycle pulse, end capture.
REQ-012 SHALL have port readout_start  input  1  single-cycle pulse, begin readout.
REQ-013 SHALL have port m_axis_tdata  output  W  readout beat.
REQ-014 SHALL have port m_axis_tvalid  output  1  readout beat valid.
REQ-015 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-016 SHALL have port m_axis_tlast  output  1  final readout beat.
REQ-017 SHALL have port word_count  output  log2(BUFFER_DEPTH)+1  beats held.
REQ-018 SHALL have port state  output  2  IDLE=0, CAPTURE=1, READOUT=2.
REQ-019 SHALL have port full  output  1  word_count == BUFFER_DEPTH.

Function
REQ-020 SHALL implement the FSM with states IDLE, CAPTURE, and READOUT.
REQ-021 SHALL assert s_axis_adc_tready whenever adc_reset is low, in every state; the ADC is never stalled.
REQ-022 SHALL, on capture_start in IDLE, zero word_count, reset the write pointer, and enter CAPTURE on the next cycle.
REQ-023 SHALL, in CAPTURE, write each beat with tvalid high to the write pointer and increment word_count and the pointer.
REQ-024 SHALL store the first beat accepted on the cycle after capture_start.
REQ-025 SHALL, in CAPTURE, return to IDLE when capture_stop is seen; the beat on the stop cycle is stored.
REQ-026 SHALL, in CAPTURE, return to IDLE in the cycle its write makes word_count reach BUFFER_DEPTH; no beat is lost or overwritten.
REQ-027 SHALL, on readout_start in IDLE with word_count>0, enter READOUT and stream word_count beats from address 0 in write order.
REQ-028 SHALL ignore readout_start when word_count==0.
REQ-029 SHALL raise m_axis_tvalid exactly two cycles after readout_start (one-cycle RAM read plus output register).
REQ-030 SHALL sustain one beat per cycle while m_axis_tready is held high.
REQ-031 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while tvalid is high and tready is low.
REQ-032 SHALL assert m_axis_tlast only on beat word_count-1.
REQ-033 SHALL return to IDLE on the cycle after the tlast handshake, with word_count retained.
REQ-034 SHALL ignore capture_start in CAPTURE and READOUT, capture_stop outside CAPTURE, and readout_start outside IDLE.
REQ-035 SHALL give start priority when capture_start and readout_start coincide in IDLE; readout_start is dropped.
REQ-036 SHALL give capture_stop and full equal effect when they coincide; the FSM goes to IDLE once.

Reset
REQ-037 SHALL, on reset, put the FSM in IDLE and clear word_count, pointers, full, m_axis_tvalid, m_axis_tlast and m_axis_tdata to 0.
REQ-038 SHALL leave RAM contents undefined after reset; reset mid-capture or mid-readout aborts with no further m_axis beats.

Configuration
REQ-039 SHALL, with macro ADC_BUFFER_CIRCULAR_EN defined, not stop CAPTURE when full and wrap the write pointer modulo BUFFER_DEPTH.
REQ-040 SHALL, with ADC_BUFFER_CIRCULAR_EN defined, saturate word_count at BUFFER_DEPTH and start readout at the oldest beat (the write pointer) once wrapped.
REQ-041 SHALL, with ADC_BUFFER_CIRCULAR_EN undefined, follow REQ-026 exactly.

Structure
REQ-042 SHALL take SAMPLE_WIDTH and PARALLEL_SAMPLES defaults and the FSM state encoding typedef from shared package daq_pkg.
REQ-043 SHALL place storage in sub-module adc_buffer_ram: simple dual-port, one write port, registered read with one-cycle latency.

Verification (BUFFER_DEPTH=16)
REQ-044 Start, 5 beats with data 1..5, stop -> word_count=5; readout with tready=1 gives 1..5 with tlast on 5, tvalid 2 cycles after readout_start.
REQ-045 Start, 20 continuous beats -> word_count=16, full=1, IDLE; readout gives beats 1..16 (17..20 dropped).
REQ-046 Readout of 8 beats with random tready (50%) -> order and data intact, outputs stable while stalled, single tlast.
REQ-047 adc_reset pulsed mid-readout after 3 beats -> tvalid=0 next cycle, word_count=0, state=IDLE; later readout_start ignored.
REQ-048 ADC_BUFFER_CIRCULAR_EN, 20 beats 1..20, stop -> word_count=16; readout gives 5..20.
REQ-049 capture_start and readout_start in the same cycle from IDLE -> CAPTURE entered, no m_axis beat.
